// File: rtl/instr_issue_queue_pkg.sv
// Shared definitions for the instruction issue queue: FSM encoding, NOP word, size defaults.
package instr_issue_queue_pkg;

    localparam int unsigned DEPTH_DEFAULT  = 8;
    localparam int unsigned DATA_W_DEFAULT = 32;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StIssue = 2'd1;
    localparam state_t StDrain = 2'd2;

endpackage

// File: rtl/instr_issue_queue_sync_fifo.sv
// Single-clock FIFO with occupancy count; storage is not reset, pointers wrap modulo DEPTH.
module sync_fifo
    import instr_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AddrW = $clog2(DEPTH);
    localparam logic [AddrW:0]   FullCount = DEPTH[AddrW:0];
    localparam logic [AddrW:0]   CountOne  = {{AddrW{1'b0}}, 1'b1};
    localparam logic [AddrW-1:0] PtrOne    = {{(AddrW-1){1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AddrW-1:0]  wr_ptr_q;
    logic [AddrW-1:0]  rd_ptr_q;
    logic [AddrW:0]    count_q;
    logic              push_ok;
    logic              pop_ok;

    assign full      = (count_q == FullCount);
    assign empty     = (count_q == '0);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CountOne;
                2'b01:   count_q <= count_q - CountOne;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/instr_issue_queue.sv
// Buffers host instruction words and issues them to a core, honouring stalls, drain and flush.
module instr_issue_queue
    import instr_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     host_valid,
    input  logic [DATA_W-1:0]        host_data,
    output logic                     host_ready,
    input  logic                     start,
    input  logic                     flush,
    input  logic                     core_stall,
    output logic [DATA_W-1:0]        instr_out,
    output logic                     instr_valid,
    output logic [7:0]               instr_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     done
);

    localparam logic [DATA_W-1:0] Nop = DATA_W'(NOP_WORD);

    state_t            state_q;
    state_t            state_d;
    logic              drain_done;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] instr_out_q;
    logic              instr_valid_q;
    logic [7:0]        instr_pc_q;
    logic [7:0]        next_pc_q;
    logic              done_q;

    assign host_ready = !full;
    assign push       = host_valid && host_ready && !flush;
    assign pop        = ((state_q == StIssue) || (state_q == StDrain)) && !empty &&
                        !core_stall && !flush;

    sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (push),
        .push_data (host_data),
        .pop       (pop),
        .head_data (head_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_comb begin
        state_d    = state_q;
        drain_done = 1'b0;
        if (flush) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) state_d = StIssue;
                end
                StIssue: begin
                    if (!start) state_d = StDrain;
                end
                StDrain: begin
                    if (start) begin
                        state_d = StIssue;
                    end else if (empty && !pop) begin
                        state_d    = StIdle;
                        drain_done = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // instr_pc only advances on a real issue; flush leaves the pc sequence intact
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            done_q        <= 1'b0;
            instr_out_q   <= Nop;
            instr_valid_q <= 1'b0;
            instr_pc_q    <= 8'd0;
            next_pc_q     <= 8'd0;
        end else begin
            state_q <= state_d;
            done_q  <= drain_done;
            if (flush) begin
                instr_out_q   <= Nop;
                instr_valid_q <= 1'b0;
            end else if (pop) begin
                instr_out_q   <= head_data;
                instr_valid_q <= 1'b1;
                instr_pc_q    <= next_pc_q;
                next_pc_q     <= next_pc_q + 8'd1;
            end else if (!core_stall) begin
                instr_out_q   <= Nop;
                instr_valid_q <= 1'b0;
            end
        end
    end

    assign instr_out   = instr_out_q;
    assign instr_valid = instr_valid_q;
    assign instr_pc    = instr_pc_q;
    assign done        = done_q;

endmodule
